regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, 32, data width in bits; SHALL be >= 8.
REQ-002 Parameter NREGS, 32, number of entries; SHALL be a power of two and >= 4; AW = log2(NREGS).
REQ-003 Parameter NRD, 2, number of read ports; SHALL be in the range 1..4.
REQ-004 Parameter ZERO_REG, 1, when 1 entry 0 SHALL read as zero and writes to entry 0 SHALL be ignored.
REQ-005 Parameter BYPASS, 1, when 1 a same-cycle write SHALL be forwarded to matching reads.
REQ-006 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst_n  in  1  reset; asynchronous, active-low.
REQ-008 rd_addr  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
REQ-009 rd_data  out  NRD*XLEN  packed read data; combinational from rd_addr.
REQ-010 we0 / wa0 / wd0  in  1 / AW / XLEN  write port 0.
REQ-011 we1 / wa1 / wd1  in  1 / AW / XLEN  write port 1.
REQ-012 clr_req  in  1  request a full-array clear; sampled only in state IDLE.
REQ-013 busy  out  1  high while a clear sweep is in progress.
REQ-014 clr_done  out  1  single-cycle pulse in the cycle that entry NREGS-1 is cleared.

Function
REQ-015 The controller SHALL have two states, CLEAR and IDLE, and an AW-bit sweep counter cnt.
REQ-016 In CLEAR, each cycle SHALL write zero to entry cnt and then increment cnt.
REQ-017 When cnt == NREGS-1 in CLEAR, the next state SHALL be IDLE, cnt SHALL wrap to 0, and clr_done SHALL be 1 for that cycle.
REQ-018 A full sweep SHALL take exactly NREGS cycles.
REQ-019 busy SHALL equal (state == CLEAR).
REQ-020 In IDLE with clr_req=1, the next state SHALL be CLEAR with cnt=0.
REQ-021 In IDLE with clr_req=1, any write enabled in that same cycle SHALL still commit.
REQ-022 clr_req SHALL be ignored while in CLEAR.
REQ-023 While busy=1, we0 and we1 SHALL be ignored.
REQ-024 While busy=1, every rd_data lane SHALL read zero.
REQ-025 In IDLE, a write with weN=1 SHALL commit wdN to entry waN at the rising edge.
REQ-026 If we0 and we1 are both high with wa0 == wa1, port 1 SHALL win and port 0's data SHALL be discarded.
REQ-027 If ZERO_REG=1, any read of address 0 SHALL return 0, with or without bypass.
REQ-028 If BYPASS=1 and in IDLE, a read whose address matches an enabled write in the same cycle SHALL return that write's data, port 1 taking priority over port 0.
REQ-029 If BYPASS=0, a read SHALL return the pre-edge array contents.
REQ-030 The read path SHALL have zero-cycle latency; the write path SHALL have one-cycle latency to the array.

Reset
REQ-031 While rst_n=0: state=CLEAR, cnt=0, busy=1, clr_done=0, rd_data=0.
REQ-032 The array itself SHALL NOT be asynchronously reset; it SHALL be zeroed by the post-reset sweep.
REQ-033 Reset asserted mid-sweep or mid-write SHALL abort the operation.
REQ-034 After such an abort, the sweep SHALL restart from entry 0 after rst_n rises.

Structure
REQ-035 Package regfile_pkg SHALL hold the state enum rf_state_t {RF_CLEAR, RF_IDLE} and the default constants for XLEN and NREGS.
REQ-036 The sweep FSM, counter and clr_done logic SHALL live in sub-module regfile_clr_ctrl, which outputs busy, clr_we and clr_addr.
REQ-037 Array write muxing, write priority and read/bypass logic SHALL remain in regfile_mp.

Verification
REQ-038 Release rst_n, NREGS=32 -> busy=1 for exactly 32 cycles, clr_done pulses in cycle 32, then all entries read 0.
REQ-039 Write 0xDEADBEEF to entry 5 via port 0, read entry 5 next cycle -> 0xDEADBEEF; same-cycle read with BYPASS=1 -> 0xDEADBEEF, with BYPASS=0 -> old value.
REQ-040 we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> entry 7 reads 0x22.
REQ-041 ZERO_REG=1, write 0x1234 to entry 0 -> entry 0 reads 0, including during the write cycle.
REQ-042 In IDLE, write 0xAA to entry 3 with clr_req=1 in the same cycle -> write commits; busy=1 for 32 cycles; then entry 3 reads 0; writes issued during busy are lost.
REQ-043 Assert rst_n=0 at sweep cycle 10, release -> sweep restarts from 0 and busy lasts a full 32 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-ported register file.
// Consumed by the clear controller and the top-level array.
package regfile_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_IDLE  = 1'b1
    } rf_state_t;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;

endpackage

// File: rtl/regfile_clr_ctrl.sv
// Array clear sequencer: sweeps every entry to zero after reset or on request,
// one entry per cycle, and reports progress to the array owner.
module regfile_clr_ctrl
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          clr_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] ONE_IDX  = AW'(1);

    rf_state_t     state_r;
    rf_state_t     state_nxt_s;
    logic [AW-1:0] cnt_r;
    logic [AW-1:0] cnt_nxt_s;
    logic          done_s;

    // State and sweep counter registers; reset lands in CLEAR so the array is zeroed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RF_CLEAR;
            cnt_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and sweep-completion decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        done_s      = 1'b0;
        case (state_r)
            RF_CLEAR: begin
                if (cnt_r == LAST_IDX) begin
                    state_nxt_s = RF_IDLE;
                    cnt_nxt_s   = {AW{1'b0}};
                    done_s      = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + ONE_IDX;
                end
            end
            RF_IDLE: begin
                if (clr_req) begin
                    state_nxt_s = RF_CLEAR;
                    cnt_nxt_s   = {AW{1'b0}};
                end else begin
                    state_nxt_s = RF_IDLE;
                end
            end
            default: begin
                state_nxt_s = RF_CLEAR;
                cnt_nxt_s   = {AW{1'b0}};
            end
        endcase
    end

    assign busy     = (state_r == RF_CLEAR);
    assign clr_we   = (state_r == RF_CLEAR);
    assign clr_addr = cnt_r;
    assign clr_done = done_s;

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with optional hard-wired zero entry and
// write-to-read forwarding; contents are zeroed by a background sweep.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEF,
    parameter int NREGS    = RF_NREGS_DEF,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                clr_req,
    output logic                busy,
    output logic                clr_done
);

    localparam logic ZERO_EN = (ZERO_REG != 0);
    localparam logic BYP_EN  = (BYPASS != 0);

    logic [XLEN-1:0] mem_r [NREGS];
    logic            busy_s;
    logic            clr_we_s;
    logic [AW-1:0]   clr_addr_s;
    logic            wen0_s;
    logic            wen1_s;
    logic [AW-1:0]   ra_s   [NRD];
    logic [XLEN-1:0] lane_s [NRD];

    regfile_clr_ctrl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s),
        .clr_done (clr_done)
    );

    assign busy   = busy_s;
    assign wen0_s = we0 && !busy_s && !(ZERO_EN && (wa0 == {AW{1'b0}}));
    assign wen1_s = we1 && !busy_s && !(ZERO_EN && (wa1 == {AW{1'b0}}));

    // Storage has no reset; port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we_s) begin
                mem_r[clr_addr_s] <= {XLEN{1'b0}};
            end else begin
                if (wen0_s) mem_r[wa0] <= wd0;
                if (wen1_s) mem_r[wa1] <= wd1;
            end
        end
    end

    // Per-lane read with zero-entry masking, busy blanking and same-cycle forwarding.
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        for (int i = 0; i < NRD; i++) begin
            ra_s[i] = rd_addr[i*AW +: AW];
            if (busy_s) begin
                lane_s[i] = {XLEN{1'b0}};
            end else if (ZERO_EN && (ra_s[i] == {AW{1'b0}})) begin
                lane_s[i] = {XLEN{1'b0}};
            end else if (BYP_EN && we1 && (wa1 == ra_s[i])) begin
                lane_s[i] = wd1;
            end else if (BYP_EN && we0 && (wa0 == ra_s[i])) begin
                lane_s[i] = wd0;
            end else begin
                lane_s[i] = mem_r[ra_s[i]];
            end
            rd_data[i*XLEN +: XLEN] = lane_s[i];
        end
    end

endmodule
